pc_sequencer: RTL

Program-counter sequencer for the 16-bit CPU: owns the PC register, drives the PC incrementer, and selects each cycle's next PC from increment, PC-relative branch, absolute jump, call or return. Sits between the control unit (which asserts the control strobes) and instruction memory (which is addressed by `PC`). Adds a boot cycle after reset, a halt/resume state, and an optional hardware return-address stack.

---
 rtl/pc_sequencer_if.sv | 30 +++
 rtl/pc_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control-strobe and PC bus between the control unit
// (master) and the program-counter sequencer (slave).
interface pc_sequencer_if;
   logic        Stall;
   logic        Halt;
   logic        Resume;
   logic        Jump;
   logic [15:0] JumpAddr;
   logic        Branch;
   logic [7:0]  BrOff;
   logic        Call;
   logic        Ret;
   logic [15:0] PC;
   logic [15:0] PCinc;
   logic        Running;
   logic [3:0]  StackDepth;
   logic        StackErr;

   // Control unit side: drives strobes, observes PC and status.
   modport master (
      output Stall, Halt, Resume, Jump, JumpAddr, Branch, BrOff, Call, Ret,
      input  PC, PCinc, Running, StackDepth, StackErr
   );

   // Sequencer side: samples strobes, drives PC and status.
   modport slave (
      input  Stall, Halt, Resume, Jump, JumpAddr, Branch, BrOff, Call, Ret,
      output PC, PCinc, Running, StackDepth, StackErr
   );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the 16-bit PC, selects next PC from increment, branch,
// jump, call or return. BOOT -> RUN after reset, RUN <-> HALTED.
// Optional hardware return-address stack enabled by defining PC_RAS_EN;
// without it Call behaves as Jump, Ret is ignored and stack status reads 0.
module pc_sequencer #(
   parameter logic [15:0] RESET_VECTOR = 16'h0000,
   parameter int          RAS_DEPTH    = 4
) (
   input  logic           CLK,
   input  logic           Reset,
   pc_sequencer_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic        running_q;
   logic [15:0] pcinc_s;
   logic [15:0] br_tgt_s;

   assign pcinc_s  = pc_q + 16'd1;
   // Branch target is relative to the incremented PC; carry out is dropped.
   assign br_tgt_s = pcinc_s + {{8{bus.BrOff[7]}}, bus.BrOff};

`ifdef PC_RAS_EN
   localparam int              PTR_W     = $clog2(RAS_DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [3:0]      DEPTH_MAX = 4'(RAS_DEPTH);

   logic [15:0]      ras_q [0:RAS_DEPTH-1];
   logic [PTR_W-1:0] sp_q;      // next slot to write; top is sp_q-1
   logic [3:0]       depth_q;
   logic             err_q;
   logic             push_s;
   logic             pop_s;
   logic [15:0]      pop_pc_s;

   // An empty pop returns the reset vector rather than stale storage.
   assign pop_pc_s = (depth_q == 4'd0) ? RESET_VECTOR : ras_q[sp_q - PTR_ONE];
`else
   logic unused_ret_s;
   assign unused_ret_s = bus.Ret;
`endif

   // Next-state and next-PC selection, strobes in priority order.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
`ifdef PC_RAS_EN
      push_s  = 1'b0;
      pop_s   = 1'b0;
`endif
      case (state_q)
         ST_BOOT: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (bus.Stall) begin
               state_d = state_q;
            end else if (bus.Halt) begin
               state_d = ST_HALTED;
`ifdef PC_RAS_EN
            end else if (bus.Ret) begin
               pop_s = 1'b1;
               pc_d  = pop_pc_s;
            end else if (bus.Call) begin
               push_s = 1'b1;
               pc_d   = bus.JumpAddr;
`endif
            end else if (bus.Call || bus.Jump) begin
               pc_d = bus.JumpAddr;
            end else if (bus.Branch) begin
               pc_d = br_tgt_s;
            end else begin
               pc_d = pcinc_s;
            end
         end
         ST_HALTED: begin
            if (bus.Resume && !bus.Stall) begin
               state_d = ST_RUN;
               pc_d    = pcinc_s;
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d = ST_BOOT;
            pc_d    = RESET_VECTOR;
         end
      endcase
   end

   // Sequencer FSM with registered PC and Running flag.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state_q   <= ST_BOOT;
         pc_q      <= RESET_VECTOR;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         running_q <= (state_d == ST_RUN);
      end
   end

`ifdef PC_RAS_EN
   // Stack pointer, depth and sticky error; full push wraps over the oldest.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         sp_q    <= '0;
         depth_q <= 4'd0;
         err_q   <= 1'b0;
      end else if (push_s) begin
         sp_q <= sp_q + PTR_ONE;
         if (depth_q == DEPTH_MAX) begin
            err_q <= 1'b1;
         end else begin
            depth_q <= depth_q + 4'd1;
         end
      end else if (pop_s) begin
         if (depth_q == 4'd0) begin
            err_q <= 1'b1;
         end else begin
            sp_q    <= sp_q - PTR_ONE;
            depth_q <= depth_q - 4'd1;
         end
      end
   end

   // Return-address storage; contents need no reset.
   always_ff @(posedge CLK) begin
      if (push_s) begin
         ras_q[sp_q] <= pcinc_s;
      end
   end

   assign bus.StackDepth = depth_q;
   assign bus.StackErr   = err_q;
`else
   assign bus.StackDepth = 4'd0;
   assign bus.StackErr   = 1'b0;
`endif

   assign bus.PC      = pc_q;
   assign bus.PCinc   = pcinc_s;
   assign bus.Running = running_q;

endmodule
